// File: rtl/bcd_mmss_counter.sv
// bcd_mmss_counter: four-digit BCD MM:SS counter driven by the slow 1 s
// square wave. The square wave is synchronised into the clk domain and its
// rising edge becomes a one-cycle tick that advances (or retreats) the count.
// Loads are range-checked; rejected loads leave the count untouched and
// raise a one-cycle load_err pulse.

module bcd_mmss_counter #(
  parameter int MM_MAX = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_1s,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] bcd,
  output logic        tick,
  output logic        wrap,
  output logic        zero,
  output logic        load_err
);

  // Minutes ceiling split into BCD digits, used for wrap detection and reload.
  localparam logic [3:0] MAX_M1 = 4'(MM_MAX / 10);
  localparam logic [3:0] MAX_M0 = 4'(MM_MAX % 10);
  localparam logic [6:0] MAX_MM = 7'(MM_MAX);
  localparam logic [15:0] TOP_VAL = {MAX_M1, MAX_M0, 4'h5, 4'h9};

  logic       s1, s2, s3;
  logic       tick_c;
  logic       load_ok;
  logic [6:0] load_mm;
  logic [15:0] next_val;
  logic        next_wrap;

  logic [3:0] m1, m0, sec1, sec0;
  logic [3:0] ld_m1, ld_m0, ld_s1, ld_s0;

  assign {m1, m0, sec1, sec0}         = bcd;
  assign {ld_m1, ld_m0, ld_s1, ld_s0} = load_val;

  assign tick_c = s2 & ~s3;
  assign zero   = (bcd == 16'h0000);

  // Load validity: each digit decimal, tens-of-seconds below 6, minutes within the ceiling.
  always_comb begin
    load_mm = ({3'b000, ld_m1} * 7'd10) + {3'b000, ld_m0};
    load_ok = (ld_m1 <= 4'd9) && (ld_m0 <= 4'd9) && (ld_s1 <= 4'd5) &&
              (ld_s0 <= 4'd9) && (load_mm <= MAX_MM);
  end

  // Next count value with per-digit carry (up) or borrow (down), plus wrap flag.
  always_comb begin
    next_val  = bcd;
    next_wrap = 1'b0;
    if (up) begin
      if (bcd == TOP_VAL) begin
        next_val  = 16'h0000;
        next_wrap = 1'b1;
      end else if (sec0 != 4'd9) begin
        next_val = {m1, m0, sec1, sec0 + 4'd1};
      end else if (sec1 != 4'd5) begin
        next_val = {m1, m0, sec1 + 4'd1, 4'd0};
      end else if (m0 != 4'd9) begin
        next_val = {m1, m0 + 4'd1, 4'd0, 4'd0};
      end else begin
        next_val = {m1 + 4'd1, 4'd0, 4'd0, 4'd0};
      end
    end else begin
      if (bcd == 16'h0000) begin
        next_val  = TOP_VAL;
        next_wrap = 1'b1;
      end else if (sec0 != 4'd0) begin
        next_val = {m1, m0, sec1, sec0 - 4'd1};
      end else if (sec1 != 4'd0) begin
        next_val = {m1, m0, sec1 - 4'd1, 4'd9};
      end else if (m0 != 4'd0) begin
        next_val = {m1, m0 - 4'd1, 4'd5, 4'd9};
      end else begin
        next_val = {m1 - 4'd1, 4'd9, 4'd5, 4'd9};
      end
    end
  end

  // Synchroniser chain for the asynchronous 1 s wave; s3 is kept for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_1s;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Count register and pulse outputs; a load takes precedence and swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd      <= 16'h0000;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= tick_c;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          bcd <= load_val;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick_c && en) begin
        bcd  <= next_val;
        wrap <= next_wrap;
      end
    end
  end

endmodule
